// File: rtl/mdrp_arbiter.sv
// mdrp_arbiter: round-robin owner of the single PLL MDRP port.
// Each grant runs one CLR/INC/read/optional-write transaction.
//
// Ports:
//   I_MD_CLK, I_RST_N     clock, sync active-low reset
//   I_REQ/ADDR/MASK/DATA  per-requester request bundle
//   O_ACK, O_ERR          completion pulse, bad-address flag
//   O_RD_DATA             register value before modification
//   O_GRANT, O_BUSY       current owner, not-idle flag
//   O_MD_INC/OPC/WR_DATA  MDRP pin drive
//   I_MD_RD_DATA          MDRP read data
module mdrp_arbiter #(
    parameter int         NREQ     = 2,
    parameter int         RD_LAT   = 2,
    parameter logic [7:0] MAX_ADDR = 8'h3F
) (
    input  logic              I_MD_CLK,
    input  logic              I_RST_N,
    input  logic [NREQ-1:0]   I_REQ,
    input  logic [NREQ*8-1:0] I_ADDR,
    input  logic [NREQ*8-1:0] I_MASK,
    input  logic [NREQ*8-1:0] I_DATA,
    output logic [NREQ-1:0]   O_ACK,
    output logic              O_ERR,
    output logic [7:0]        O_RD_DATA,
    output logic [NREQ-1:0]   O_GRANT,
    output logic              O_BUSY,
    output logic              O_MD_INC,
    output logic [1:0]        O_MD_OPC,
    output logic [7:0]        O_MD_WR_DATA,
    input  logic [7:0]        I_MD_RD_DATA
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OPC_CLR = 2'b00;
    localparam logic [1:0] OPC_WR  = 2'b01;
    localparam logic [1:0] OPC_NOP = 2'b10;

    typedef enum logic [2:0] {
        IDLE, CLR, INC, SETTLE, READ, WRITE, ACK
    } state_t;

    state_t          state, stateNxt;
    logic [7:0]      cnt, cntNxt;
    logic [7:0]      settleCnt, settleNxt;
    logic [IDXW-1:0] rrPtr, rrNxt;
    logic [IDXW-1:0] grantIdx, idxNxt;
    logic [7:0]      addrQ, addrNxt;
    logic [7:0]      maskQ, maskNxt;
    logic [7:0]      dataQ, dataNxt;
    logic [7:0]      rdQ, rdNxt;

    logic [NREQ-1:0] ackNxt, grantNxt;
    logic            errNxt, busyNxt, incNxt;
    logic [1:0]      opcNxt;
    logic [7:0]      wrNxt, rdDataNxt;

    logic            reqHit;
    logic [IDXW-1:0] winIdx, cand;
    logic [7:0]      winAddr, winMask, winData;

    function automatic logic [NREQ-1:0] oneHot(
        input logic [IDXW-1:0] idx
    );
        logic [NREQ-1:0] v;
        v = '0;
        for (int k = 0; k < NREQ; k++) begin
            v[k] = (idx == IDXW'(k));
        end
        return v;
    endfunction

    // First request at or after rrPtr, upward modulo NREQ.
    always_comb begin
        reqHit  = 1'b0;
        winIdx  = '0;
        cand    = '0;
        winAddr = '0;
        winMask = '0;
        winData = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDXW'((int'(rrPtr) + i) % NREQ);
            if (!reqHit && I_REQ[cand]) begin
                reqHit = 1'b1;
                winIdx = cand;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (winIdx == IDXW'(k)) begin
                winAddr = I_ADDR[8*k +: 8];
                winMask = I_MASK[8*k +: 8];
                winData = I_DATA[8*k +: 8];
            end
        end
    end

    // Outputs are registered, so they are computed here
    // for the state being entered.
    always_comb begin
        stateNxt  = state;
        cntNxt    = cnt;
        settleNxt = settleCnt;
        rrNxt     = rrPtr;
        idxNxt    = grantIdx;
        addrNxt   = addrQ;
        maskNxt   = maskQ;
        dataNxt   = dataQ;
        rdNxt     = rdQ;
        incNxt    = 1'b0;
        opcNxt    = OPC_NOP;
        wrNxt     = O_MD_WR_DATA;
        rdDataNxt = O_RD_DATA;
        errNxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (reqHit) begin
                    idxNxt  = winIdx;
                    addrNxt = winAddr;
                    maskNxt = winMask;
                    dataNxt = winData;
                    if (winAddr > MAX_ADDR) begin
                        stateNxt  = ACK;
                        errNxt    = 1'b1;
                        rdDataNxt = '0;
                    end else begin
                        stateNxt = CLR;
                        opcNxt   = OPC_CLR;
                    end
                end
            end
            CLR: begin
                cntNxt = '0;
                if (addrQ == 8'd0) begin
                    stateNxt  = SETTLE;
                    settleNxt = '0;
                end else begin
                    stateNxt = INC;
                    incNxt   = 1'b1;
                end
            end
            INC: begin
                cntNxt = cnt + 8'd1;
                if (cnt + 8'd1 == addrQ) begin
                    stateNxt  = SETTLE;
                    settleNxt = '0;
                end else begin
                    incNxt = 1'b1;
                end
            end
            SETTLE: begin
                if (settleCnt == 8'(RD_LAT - 1)) begin
                    stateNxt = READ;
                end else begin
                    settleNxt = settleCnt + 8'd1;
                end
            end
            READ: begin
                rdNxt = I_MD_RD_DATA;
                if (maskQ == 8'd0) begin
                    stateNxt  = ACK;
                    rdDataNxt = I_MD_RD_DATA;
                end else begin
                    stateNxt = WRITE;
                    opcNxt   = OPC_WR;
                    wrNxt    = (I_MD_RD_DATA & ~maskQ)
                             | (dataQ & maskQ);
                end
            end
            WRITE: begin
                stateNxt  = ACK;
                rdDataNxt = rdQ;
            end
            ACK: begin
                stateNxt = IDLE;
                if (grantIdx == IDXW'(NREQ - 1)) begin
                    rrNxt = '0;
                end else begin
                    rrNxt = grantIdx + 1'b1;
                end
            end
            default: stateNxt = IDLE;
        endcase

        busyNxt  = (stateNxt != IDLE);
        grantNxt = busyNxt ? oneHot(idxNxt) : '0;
        ackNxt   = (stateNxt == ACK) ? oneHot(idxNxt) : '0;
    end

    always_ff @(posedge I_MD_CLK) begin
        if (!I_RST_N) begin
            state        <= IDLE;
            cnt          <= '0;
            settleCnt    <= '0;
            rrPtr        <= '0;
            grantIdx     <= '0;
            addrQ        <= '0;
            maskQ        <= '0;
            dataQ        <= '0;
            rdQ          <= '0;
            O_ACK        <= '0;
            O_ERR        <= 1'b0;
            O_RD_DATA    <= '0;
            O_GRANT      <= '0;
            O_BUSY       <= 1'b0;
            O_MD_INC     <= 1'b0;
            O_MD_OPC     <= OPC_NOP;
            O_MD_WR_DATA <= '0;
        end else begin
            state        <= stateNxt;
            cnt          <= cntNxt;
            settleCnt    <= settleNxt;
            rrPtr        <= rrNxt;
            grantIdx     <= idxNxt;
            addrQ        <= addrNxt;
            maskQ        <= maskNxt;
            dataQ        <= dataNxt;
            rdQ          <= rdNxt;
            O_ACK        <= ackNxt;
            O_ERR        <= errNxt;
            O_RD_DATA    <= rdDataNxt;
            O_GRANT      <= grantNxt;
            O_BUSY       <= busyNxt;
            O_MD_INC     <= incNxt;
            O_MD_OPC     <= opcNxt;
            O_MD_WR_DATA <= wrNxt;
        end
    end

endmodule

// File: tb/tb_mdrp_arbiter.sv
// tb_mdrp_arbiter: directed bench for mdrp_arbiter with a
// small MDRP register-file model behind the pins.
module tb_mdrp_arbiter;

    localparam int NREQ   = 2;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rstN;
    logic [1:0]  req;
    logic [15:0] addrV, maskV, dataV;
    logic [1:0]  ack, grant;
    logic        err, busy, mdInc;
    logic [7:0]  rdData, mdWr, mdRd;
    logic [1:0]  mdOpc;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mdrp_arbiter #(
        .NREQ(NREQ), .RD_LAT(RD_LAT), .MAX_ADDR(8'h3F)
    ) dut (
        .I_MD_CLK(clk), .I_RST_N(rstN), .I_REQ(req),
        .I_ADDR(addrV), .I_MASK(maskV), .I_DATA(dataV),
        .O_ACK(ack), .O_ERR(err), .O_RD_DATA(rdData),
        .O_GRANT(grant), .O_BUSY(busy), .O_MD_INC(mdInc),
        .O_MD_OPC(mdOpc), .O_MD_WR_DATA(mdWr),
        .I_MD_RD_DATA(mdRd)
    );

    // PLL register file: pointer, RD_LAT-deep read pipe.
    logic [7:0] regs [0:255];
    logic [7:0] ptr = 8'd0;
    logic [7:0] nptr;
    logic [7:0] pipe0 = 8'd0, pipe1 = 8'd0;
    logic [7:0] lastWr = 8'd0;
    int         incCnt = 0, wrCnt = 0, clrCnt = 0;
    logic       pokeEn = 1'b0;
    logic [7:0] pokeAddr = 8'd0, pokeVal = 8'd0;

    always @(posedge clk) begin
        nptr = ptr;
        if (mdOpc == 2'b00) begin
            nptr = 8'd0;
            clrCnt <= clrCnt + 1;
        end else if (mdInc) begin
            nptr = ptr + 8'd1;
        end
        if (mdInc) incCnt <= incCnt + 1;
        if (mdOpc == 2'b01) begin
            regs[ptr] <= mdWr;
            lastWr    <= mdWr;
            wrCnt     <= wrCnt + 1;
        end
        if (pokeEn) regs[pokeAddr] <= pokeVal;
        ptr   <= nptr;
        pipe0 <= regs[nptr];
        pipe1 <= pipe0;
    end
    assign mdRd = pipe1;

    typedef struct {
        int         k;
        logic [7:0] addr, mask, data, preset, expRd;
        logic       expErr;
        int         expLat, expInc, expWr;
        logic [7:0] expReg;
    } vec_t;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        pokeAddr = a;
        pokeVal  = v;
        pokeEn   = 1'b1;
        @(negedge clk);
        pokeEn = 1'b0;
    endtask

    task automatic waitAck(output int n, output logic [1:0] ackv);
        bit done;
        done = 0;
        n    = 0;
        ackv = '0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (ack != 2'b00) begin
                ackv = ack;
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL ack timeout: none in %0d cycles, expected one",
                     n);
            n = -1;
        end
    endtask

    task automatic checkResetVals(input string tag);
        check({tag, " ack"},   ack,    2'b00);
        check({tag, " err"},   err,    1'b0);
        check({tag, " rd"},    rdData, 8'h00);
        check({tag, " grant"}, grant,  2'b00);
        check({tag, " busy"},  busy,   1'b0);
        check({tag, " inc"},   mdInc,  1'b0);
        check({tag, " opc"},   mdOpc,  2'b10);
        check({tag, " wr"},    mdWr,   8'h00);
    endtask

    task automatic doTxn(input vec_t v, input string tag);
        int         n, i0, w0, c0;
        logic [1:0] ackv, oh;
        oh = 2'(1 << v.k);
        poke(v.addr, v.preset);
        i0 = incCnt;
        w0 = wrCnt;
        c0 = clrCnt;
        addrV[8*v.k +: 8] = v.addr;
        maskV[8*v.k +: 8] = v.mask;
        dataV[8*v.k +: 8] = v.data;
        req[v.k] = 1'b1;
        waitAck(n, ackv);
        check({tag, " latency"}, n, v.expLat);
        check({tag, " ack"}, ackv, oh);
        check({tag, " grant"}, grant, oh);
        check({tag, " err"}, err, v.expErr);
        check({tag, " rddata"}, rdData, v.expRd);
        req[v.k] = 1'b0;
        @(negedge clk);
        check({tag, " idle busy"}, busy, 1'b0);
        check({tag, " idle grant"}, grant, 2'b00);
        check({tag, " inc pulses"}, incCnt - i0, v.expInc);
        check({tag, " writes"}, wrCnt - w0, v.expWr);
        check({tag, " clears"}, clrCnt - c0, v.expErr ? 0 : 1);
        if (v.expWr > 0) check({tag, " wrdata"}, lastWr, v.expReg);
    endtask

    vec_t vecs [7];

    initial begin
        int         n, pulses, guard, w0;
        logic [1:0] ackv;
        vec_t       tv;

        vecs[0] = '{0, 8'h11, 8'h07, 8'h03, 8'hF4, 8'hF4,
                    1'b0, 23, 17, 1, 8'hF3};
        vecs[1] = '{1, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A,
                    1'b0, 5, 0, 0, 8'h00};
        vecs[2] = '{0, 8'h40, 8'hFF, 8'h00, 8'h00, 8'h00,
                    1'b1, 1, 0, 0, 8'h00};
        vecs[3] = '{1, 8'h3F, 8'hF0, 8'hA5, 8'h3C, 8'h3C,
                    1'b0, 69, 63, 1, 8'hAC};
        vecs[4] = '{0, 8'h01, 8'hFF, 8'h77, 8'h12, 8'h12,
                    1'b0, 7, 1, 1, 8'h77};
        vecs[5] = '{0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                    1'b1, 1, 0, 0, 8'h00};
        vecs[6] = '{1, 8'h05, 8'h00, 8'h00, 8'h99, 8'h99,
                    1'b0, 10, 5, 0, 8'h00};

        rstN  = 1'b0;
        req   = 2'b00;
        addrV = '0;
        maskV = '0;
        dataV = '0;
        repeat (3) @(negedge clk);
        checkResetVals("reset");
        rstN = 1'b1;

        for (int i = 0; i < 7; i++) begin
            doTxn(vecs[i], $sformatf("vec%0d", i));
        end

        // Round robin: pointer is 0 after vec6 (requester 1).
        poke(8'h00, 8'h21);
        addrV = '0;
        maskV = '0;
        req   = 2'b11;
        waitAck(n, ackv);
        check("rr1 first ack", ackv, 2'b01);
        check("rr1 first lat", n, 5);
        check("rr1 first rd", rdData, 8'h21);
        req[0] = 1'b0;
        waitAck(n, ackv);
        check("rr1 second ack", ackv, 2'b10);
        check("rr1 second lat", n, 6);
        req[1] = 1'b0;
        @(negedge clk);
        tv = '{0, 8'h00, 8'h00, 8'h00, 8'h21, 8'h21,
               1'b0, 5, 0, 0, 8'h00};
        doTxn(tv, "rr solo0");
        req = 2'b11;
        waitAck(n, ackv);
        check("rr2 first ack", ackv, 2'b10);
        check("rr2 first lat", n, 5);
        req[1] = 1'b0;
        waitAck(n, ackv);
        check("rr2 second ack", ackv, 2'b01);
        check("rr2 second lat", n, 6);
        req[0] = 1'b0;
        @(negedge clk);

        // Reset during INC pulse 5 of 12, then retry.
        poke(8'h0C, 8'h66);
        addrV[7:0] = 8'h0C;
        maskV[7:0] = 8'hFF;
        dataV[7:0] = 8'h55;
        req[0]     = 1'b1;
        pulses     = 0;
        guard      = 0;
        while (pulses < 5 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (mdInc) pulses++;
        end
        check("rst reached pulse5", pulses, 5);
        rstN = 1'b0;
        req  = 2'b00;
        @(negedge clk);
        checkResetVals("midrst");
        rstN = 1'b1;
        tv = '{0, 8'h0C, 8'hFF, 8'h55, 8'h66, 8'h66,
               1'b0, 18, 12, 1, 8'h55};
        doTxn(tv, "retry");

        // Input change after grant, then request held past ACK.
        poke(8'h03, 8'hF0);
        w0          = wrCnt;
        addrV[15:8] = 8'h03;
        maskV[15:8] = 8'h0F;
        dataV[15:8] = 8'h0A;
        req[1]      = 1'b1;
        @(negedge clk);
        dataV[15:8] = 8'h05;
        waitAck(n, ackv);
        check("latch lat", n, 8);
        check("latch ack", ackv, 2'b10);
        check("latch rd", rdData, 8'hF0);
        check("latch wrdata", lastWr, 8'hFA);
        waitAck(n, ackv);
        check("hold lat", n, 10);
        check("hold ack", ackv, 2'b10);
        check("hold rd", rdData, 8'hFA);
        check("hold wrdata", lastWr, 8'hF5);
        req[1] = 1'b0;
        @(negedge clk);
        check("hold writes", wrCnt - w0, 2);
        check("hold busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected done");
        $fatal(1, "watchdog");
    end

endmodule
